// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
// Turns the divided slow clock into a single-cycle CPU clock-enable in the
// fast clk domain. Supports free-run (run switch), single-step (debounced push
// button) and a CPU-requested halt, and counts the enables it has issued.
//
// Ports
//   clk       in   1      system clock
//   rst       in   1      asynchronous reset, active-high
//   slow_in   in   1      divided clock, asynchronous to clk
//   run       in   1      free-run switch, raw level
//   step_btn  in   1      raw single-step push button (bouncy)
//   halt      in   1      halt request from CPU, synchronous to clk
//   cpu_en    out  1      one-clk-wide CPU advance pulse, registered
//   state     out  2      00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   en_count  out  CNT_W  number of cpu_en pulses issued, wraps
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_in,
    input  logic             run,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] en_count
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    logic [SYNC_STAGES-1:0] slow_sync_q;
    logic                   slow_prev_q;
    logic [SYNC_STAGES-1:0] run_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;

    logic                   db_lvl_q;
    logic                   db_lvl_d;
    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic                   db_prev_q;

    state_e                 state_q;
    logic                   cpu_en_q;
    logic [CNT_W-1:0]       en_count_q;

    logic                   slow_rise_s;
    logic                   run_s;
    logic                   btn_s;
    logic                   press_s;

    assign slow_rise_s = slow_sync_q[SYNC_STAGES-1] & ~slow_prev_q;
    assign run_s       = run_sync_q[SYNC_STAGES-1];
    assign btn_s       = btn_sync_q[SYNC_STAGES-1];
    // One-cycle pulse on the debounced 0->1 transition.
    assign press_s     = db_lvl_q & ~db_prev_q;

    // Synchronizer chains for the asynchronous inputs plus the slow edge-detect flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_sync_q <= {SYNC_STAGES{1'b0}};
            slow_prev_q <= 1'b0;
            run_sync_q  <= {SYNC_STAGES{1'b0}};
            btn_sync_q  <= {SYNC_STAGES{1'b0}};
        end else begin
            slow_sync_q <= {slow_sync_q[SYNC_STAGES-2:0], slow_in};
            slow_prev_q <= slow_sync_q[SYNC_STAGES-1];
            run_sync_q  <= {run_sync_q[SYNC_STAGES-2:0], run};
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], step_btn};
        end
    end

    // Debounce next state: a new level is accepted only after DEBOUNCE_CYCLES
    // consecutive samples that differ from the current debounced level.
    always_comb begin
        db_lvl_d = db_lvl_q;
        db_cnt_d = db_cnt_q;
        if (btn_s != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = btn_s;
                db_cnt_d = {DB_W{1'b0}};
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1'b1);
            end
        end else begin
            db_cnt_d = {DB_W{1'b0}};
        end
    end

    // Debounce registers and the previous debounced level for press detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_lvl_q  <= 1'b0;
            db_cnt_q  <= {DB_W{1'b0}};
            db_prev_q <= 1'b0;
        end else begin
            db_lvl_q  <= db_lvl_d;
            db_cnt_q  <= db_cnt_d;
            db_prev_q <= db_lvl_q;
        end
    end

    // Control FSM with registered cpu_en pulse and enable counter.
    // cpu_en defaults low every cycle, so it can never stay high for two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cpu_en_q   <= 1'b0;
            en_count_q <= {CNT_W{1'b0}};
        end else begin
            cpu_en_q <= 1'b0;
            if (halt) begin
                // Halt overrides everything, including a coincident slow rise.
                state_q <= ST_HALTED;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (run_s) begin
                            state_q <= ST_RUN;
                        end else if (press_s) begin
                            state_q <= ST_STEP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (!run_s) begin
                            state_q <= ST_IDLE;
                        end else if (slow_rise_s) begin
                            cpu_en_q   <= 1'b1;
                            en_count_q <= en_count_q + CNT_W'(1'b1);
                            state_q    <= ST_RUN;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_STEP: begin
                        // Extra presses are ignored here; run=1 drops the pending step.
                        if (slow_rise_s) begin
                            cpu_en_q   <= 1'b1;
                            en_count_q <= en_count_q + CNT_W'(1'b1);
                            state_q    <= ST_IDLE;
                        end else if (run_s) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_STEP;
                        end
                    end
                    ST_HALTED: begin
                        // Leaving needs run low too, so a halted program restarts
                        // only after the run switch is cycled.
                        if (!run_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_HALTED;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cpu_en   = cpu_en_q;
    assign state    = state_q;
    assign en_count = en_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
// Scoreboard bench: stimulus pushes the expected (en_count, state) for every
// cpu_en pulse it intends to cause; an independent monitor pops and compares
// on each pulse and also checks pulse width and latency from the slow rise.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_in;
    logic       run;
    logic       step_btn;
    logic       halt;
    logic       cpu_en;
    logic [1:0] state;
    logic [3:0] en_count;

    typedef struct {
        logic [3:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int sample_edge = 0;
    bit slow_on  = 1'b0;
    int ph       = 19;

    cpu_step_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .slow_in (slow_in),
        .run     (run),
        .step_btn(step_btn),
        .halt    (halt),
        .cpu_en  (cpu_en),
        .state   (state),
        .en_count(en_count)
    );

    always #5 clk = ~clk;

    // Edge counter: value after posedge k is k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int cnt, input logic [1:0] st);
        exp_t e;
        e.cnt = cnt[3:0];
        e.st  = st;
        exp_q.push_back(e);
    endtask

    // Slow clock generator: period 20 clk, driven on negedge, records the
    // posedge that first samples each rise.
    initial begin
        slow_in = 1'b0;
        forever begin
            @(negedge clk);
            if (slow_on) begin
                ph = (ph == 19) ? 0 : ph + 1;
                slow_in = (ph < 10);
                if (ph == 0) sample_edge = cyc + 1;
            end else begin
                ph = 19;
                slow_in = 1'b0;
            end
        end
    end

    // Monitor: every cpu_en pulse must match the next scoreboard entry.
    initial begin
        exp_t e;
        bit   prev_en;
        prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (cpu_en === 1'b1) begin
                check("en_width", {31'd0, prev_en}, 32'd0);
                check("en_latency", cyc - sample_edge, SYNC);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pulse: got cpu_en=1 expected none (count=%0d state=%0b t=%0t)",
                             en_count, state, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_count", en_count, e.cnt);
                    check("pulse_state", state, e.st);
                end
            end
            prev_en = (cpu_en === 1'b1);
        end
    end

    initial begin
        rst = 1'b1; run = 1'b1; step_btn = 1'b0; halt = 1'b0;
        slow_on = 1'b1;

        // 1: reset held with slow_in toggling and run high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_en", cpu_en, 0);
            check("rst_state", state, 2'b00);
            check("rst_count", en_count, 0);
        end
        @(posedge clk); #1 slow_on = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("release_idle", state, 2'b00);
        tick(4);
        check("release_run", state, 2'b01);
        run = 1'b0;
        tick(5);
        check("run_off_idle", state, 2'b00);

        // 2: free run for five slow periods.
        run = 1'b1;
        tick(4);
        check("run_state", state, 2'b01);
        for (int i = 1; i <= 5; i++) push(i, 2'b01);
        slow_on = 1'b1;
        tick(90);
        slow_on = 1'b0;
        tick(3);
        check("run_count", en_count, 5);
        check("run_state2", state, 2'b01);
        check("run_q_empty", exp_q.size(), 0);
        run = 1'b0;
        tick(5);
        check("run_idle", state, 2'b00);

        // 3: single step via a clean 10-cycle press.
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        check("step_state", state, 2'b10);
        tick(10);
        check("step_hold", state, 2'b10);
        push(6, 2'b00);
        slow_on = 1'b1;
        tick(30);
        slow_on = 1'b0;
        tick(3);
        check("step_idle", state, 2'b00);
        check("step_count", en_count, 6);
        check("step_q_empty", exp_q.size(), 0);
        // short glitches are rejected
        for (int w = 1; w <= 3; w++) begin
            step_btn = 1'b1;
            tick(w);
            step_btn = 1'b0;
            tick(12);
            check("glitch_state", state, 2'b00);
        end

        // 4: halt coincident with a slow rise.
        run = 1'b1;
        tick(5);
        check("halt_pre_run", state, 2'b01);
        slow_on = 1'b1;
        tick(2);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        @(negedge clk);
        check("halt_state", state, 2'b11);
        check("halt_count", en_count, 6);
        tick(10);
        slow_on = 1'b0;
        check("halt_run_stays", state, 2'b11);
        tick(5);
        run = 1'b0;
        tick(2);
        @(negedge clk);
        check("halt_sync_lat", state, 2'b11);
        tick(1);
        @(negedge clk);
        check("halt_exit", state, 2'b00);

        // 5: counter wrap with 17 slow rises.
        tick(1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("wrap_rst_count", en_count, 0);
        tick(1);
        run = 1'b1;
        tick(5);
        for (int i = 1; i <= 17; i++) push(i % 16, 2'b01);
        slow_on = 1'b1;
        tick(330);
        slow_on = 1'b0;
        tick(3);
        check("wrap_count", en_count, 1);
        check("wrap_q_empty", exp_q.size(), 0);
        run = 1'b0;
        tick(5);

        // 6: reset while a step is pending.
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        check("mid_step_state", state, 2'b10);
        rst = 1'b1;
        slow_on = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(45);
        slow_on = 1'b0;
        @(negedge clk);
        check("mid_rst_state", state, 2'b00);
        check("mid_rst_count", en_count, 0);

        tick(5);
        check("final_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
